lycan_pin_router: RTL and testbench

- Runtime-configurable crossbar between the peripheral array and the DUT pins.
- Fully parametrised in pin count, peripheral count and per-peripheral input/output/tristate counts.
- Configured by command packets from the USB packet path into a shadow table; a commit makes the shadow table active atomically.
- Synchronises asynchronous DUT pin inputs before routing them to peripheral inputs.

---
 rtl/lycan_pin_router_if.sv | 21 ++
 rtl/lycan_pin_router.sv | 200 ++++++++++++++++++++
 tb/tb_lycan_pin_router.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lycan_pin_router_if.sv
// Command packet bus into the pin router: a plain valid/ready handshake
// carrying one configuration packet per accepted cycle.
interface lycan_pin_router_if #(
    parameter int PACKET_WIDTH = 32
);
    logic [PACKET_WIDTH-1:0] pkt_data;
    logic                    pkt_valid;
    logic                    pkt_ready;

    modport master (
        output pkt_data,
        output pkt_valid,
        input  pkt_ready
    );

    modport slave (
        input  pkt_data,
        input  pkt_valid,
        output pkt_ready
    );
endinterface

// File: rtl/lycan_pin_router.sv
// Runtime-configurable crossbar between peripheral slots and DUT pins, loaded
// through a shadow table that a COMMIT packet copies into the active table.
module lycan_pin_router #(
    parameter int NUM_DUT_PINS         = 16,
    parameter int NUM_PERIPHERALS      = 8,
    parameter int INPUTS_PER_PERIPH    = 3,
    parameter int OUTPUTS_PER_PERIPH   = 4,
    parameter int TRISTATES_PER_PERIPH = 1,
    parameter int PACKET_WIDTH         = 32
) (
    input  logic                                            clk,
    input  logic                                            rst,
    lycan_pin_router_if.slave                               pkt,
    input  logic [NUM_PERIPHERALS*OUTPUTS_PER_PERIPH-1:0]   periph_out,
    input  logic [NUM_PERIPHERALS*TRISTATES_PER_PERIPH-1:0] periph_oe,
    output logic [NUM_PERIPHERALS*INPUTS_PER_PERIPH-1:0]    periph_in,
    input  logic [NUM_DUT_PINS-1:0]                         dut_pin_in,
    output logic [NUM_DUT_PINS-1:0]                         dut_pin_out,
    output logic [NUM_DUT_PINS-1:0]                         dut_pin_oe,
    output logic                                            cfg_err
);
    localparam int PW  = $clog2(NUM_DUT_PINS);
    localparam int AW  = $clog2(NUM_PERIPHERALS);
    localparam int OW  = (OUTPUTS_PER_PERIPH > 1) ? $clog2(OUTPUTS_PER_PERIPH) : 1;
    localparam int IW  = (INPUTS_PER_PERIPH > 1) ? $clog2(INPUTS_PER_PERIPH) : 1;
    localparam int XW  = (OW > IW) ? OW : IW;
    localparam int OSW = (NUM_PERIPHERALS*OUTPUTS_PER_PERIPH > 1) ?
                         $clog2(NUM_PERIPHERALS*OUTPUTS_PER_PERIPH) : 1;
    localparam int TSW = (NUM_PERIPHERALS*TRISTATES_PER_PERIPH > 1) ?
                         $clog2(NUM_PERIPHERALS*TRISTATES_PER_PERIPH) : 1;
    localparam int TOP = PACKET_WIDTH - 3;

    if (2 + PW + AW + XW + 1 > PACKET_WIDTH) begin : g_width_check
        $error("lycan_pin_router: PACKET_WIDTH too small for command fields");
    end

    typedef enum logic [1:0] {
        OP_CLEAR  = 2'b00,
        OP_PINMAP = 2'b01,
        OP_INMAP  = 2'b10,
        OP_COMMIT = 2'b11
    } op_t;

    typedef enum logic {S_RUN, S_COPY} state_t;

    typedef struct packed {
        logic [AW-1:0] periph;
        logic [OW-1:0] out_idx;
        logic          en;
    } pin_entry_t;

    typedef struct packed {
        logic [PW-1:0] pin;
        logic          en;
    } in_entry_t;

    pin_entry_t shadow_pin [NUM_DUT_PINS];
    pin_entry_t active_pin [NUM_DUT_PINS];
    in_entry_t  shadow_in  [NUM_PERIPHERALS][INPUTS_PER_PERIPH];
    in_entry_t  active_in  [NUM_PERIPHERALS][INPUTS_PER_PERIPH];

    state_t state, state_next;
    logic   ready, accept, copy;

    // Field decode; both layouts are packed from just below the opcode.
    op_t           op;
    logic [PW-1:0] pm_pin;
    logic [AW-1:0] pm_periph;
    logic [OW-1:0] pm_out;
    logic          pm_en, pm_ok;
    logic [AW-1:0] im_periph;
    logic [IW-1:0] im_idx;
    logic [PW-1:0] im_pin;
    logic          im_en, im_ok;
    logic          unused_pkt_lsbs;

    assign op        = op_t'(pkt.pkt_data[PACKET_WIDTH-1 -: 2]);
    assign pm_pin    = pkt.pkt_data[TOP -: PW];
    assign pm_periph = pkt.pkt_data[TOP-PW -: AW];
    assign pm_out    = pkt.pkt_data[TOP-PW-AW -: OW];
    assign pm_en     = pkt.pkt_data[TOP-PW-AW-OW];
    assign im_periph = pkt.pkt_data[TOP -: AW];
    assign im_idx    = pkt.pkt_data[TOP-AW -: IW];
    assign im_pin    = pkt.pkt_data[TOP-AW-IW -: PW];
    assign im_en     = pkt.pkt_data[TOP-AW-IW-PW];
    assign unused_pkt_lsbs = ^pkt.pkt_data;

    assign pm_ok = (int'(pm_pin) < NUM_DUT_PINS) && (int'(pm_periph) < NUM_PERIPHERALS) &&
                   (int'(pm_out) < OUTPUTS_PER_PERIPH);
    assign im_ok = (int'(im_pin) < NUM_DUT_PINS) && (int'(im_periph) < NUM_PERIPHERALS) &&
                   (int'(im_idx) < INPUTS_PER_PERIPH);

    always_ff @(posedge clk) begin
        if (rst) state <= S_RUN;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can leave one
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        ready      = 1'b0;
        copy       = 1'b0;
        case (state)
            S_RUN: begin
                ready = !rst;
                if (pkt.pkt_valid && ready && op == OP_COMMIT) state_next = S_COPY;
            end
            S_COPY: begin
                copy       = 1'b1;
                state_next = S_RUN;
            end
            default: state_next = S_RUN;
        endcase
    end

    assign accept        = pkt.pkt_valid && ready;
    assign pkt.pkt_ready = ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the tables are reset explicitly because reset must leave every route
            // disabled, not merely holding whatever was last written.
            for (int k = 0; k < NUM_DUT_PINS; k++) shadow_pin[k] <= '0;
            for (int p = 0; p < NUM_PERIPHERALS; p++)
                for (int i = 0; i < INPUTS_PER_PERIPH; i++) shadow_in[p][i] <= '0;
        end else if (accept) begin
            if (op == OP_PINMAP && pm_ok)
                shadow_pin[pm_pin] <= '{periph: pm_periph, out_idx: pm_out, en: pm_en};
            if (op == OP_INMAP && im_ok)
                shadow_in[im_periph][im_idx] <= '{pin: im_pin, en: im_en};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_DUT_PINS; k++) active_pin[k] <= '0;
            for (int p = 0; p < NUM_PERIPHERALS; p++)
                for (int i = 0; i < INPUTS_PER_PERIPH; i++) active_in[p][i] <= '0;
        end else if (copy) begin
            active_pin <= shadow_pin;
            active_in  <= shadow_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else if (accept) begin
            if (op == OP_CLEAR)
                cfg_err <= 1'b0;
            else if ((op == OP_PINMAP && !pm_ok) || (op == OP_INMAP && !im_ok))
                cfg_err <= 1'b1;
        end
    end

    // Routing muxes; the enable of output o is tristate (o mod TRISTATES_PER_PERIPH).
    logic [NUM_DUT_PINS-1:0]                      route_out, route_oe;
    logic [NUM_PERIPHERALS*INPUTS_PER_PERIPH-1:0] route_in;
    logic [NUM_DUT_PINS-1:0]                      sync_q1, sync_q2;
    logic [OSW-1:0]                               o_sel;
    logic [TSW-1:0]                               t_sel;

    always_comb begin
        route_out = '0;
        route_oe  = '0;
        route_in  = '0;
        o_sel     = '0;
        t_sel     = '0;
        for (int k = 0; k < NUM_DUT_PINS; k++) begin
            o_sel = OSW'(int'(active_pin[k].periph) * OUTPUTS_PER_PERIPH +
                         int'(active_pin[k].out_idx));
            t_sel = TSW'(int'(active_pin[k].periph) * TRISTATES_PER_PERIPH +
                         (int'(active_pin[k].out_idx) % TRISTATES_PER_PERIPH));
            route_out[k] = active_pin[k].en & periph_out[o_sel];
            route_oe[k]  = active_pin[k].en & periph_oe[t_sel];
        end
        for (int p = 0; p < NUM_PERIPHERALS; p++)
            for (int i = 0; i < INPUTS_PER_PERIPH; i++)
                route_in[p*INPUTS_PER_PERIPH+i] = active_in[p][i].en & sync_q2[active_in[p][i].pin];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1     <= '0;
            sync_q2     <= '0;
            dut_pin_out <= '0;
            dut_pin_oe  <= '0;
            periph_in   <= '0;
        end else begin
            // NOTE: non-blocking so sync_q2 takes the previous sync_q1, giving two real
            // synchroniser stages instead of one collapsed flop.
            sync_q1     <= dut_pin_in;
            sync_q2     <= sync_q1;
            dut_pin_out <= route_out;
            dut_pin_oe  <= route_oe;
            periph_in   <= route_in;
        end
    end
endmodule

// File: tb/tb_lycan_pin_router.sv
// Scenario bench for lycan_pin_router: expected output snapshots are queued as
// stimulus is driven and popped/compared at negedges as the DUT responds.
module tb_lycan_pin_router;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] periph_out;
    logic [7:0]  periph_oe;
    logic [23:0] periph_in;
    logic [15:0] dut_pin_in, dut_pin_out, dut_pin_oe;
    logic        cfg_err;

    always #5 clk = ~clk;

    lycan_pin_router_if #(.PACKET_WIDTH(32)) pkt_if ();

    lycan_pin_router #(
        .NUM_DUT_PINS(16), .NUM_PERIPHERALS(8), .INPUTS_PER_PERIPH(3),
        .OUTPUTS_PER_PERIPH(4), .TRISTATES_PER_PERIPH(1), .PACKET_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .pkt(pkt_if),
        .periph_out(periph_out), .periph_oe(periph_oe), .periph_in(periph_in),
        .dut_pin_in(dut_pin_in), .dut_pin_out(dut_pin_out), .dut_pin_oe(dut_pin_oe),
        .cfg_err(cfg_err)
    );

    typedef struct packed {
        logic [15:0] pin_out;
        logic [15:0] pin_oe;
        logic [23:0] pin_in;
        logic        ready;
        logic        err;
    } snap_t;

    typedef struct {
        string tag;
        snap_t v;
    } exp_t;

    exp_t  sb[$];
    exp_t  e;
    snap_t obs;
    int    checks = 0;
    int    failures = 0;

    assign obs = {dut_pin_out, dut_pin_oe, periph_in, pkt_if.pkt_ready, cfg_err};

    localparam logic [31:0] COMMIT = 32'hC000_0000;

    function automatic snap_t mk(input logic [15:0] o, input logic [15:0] oe,
                                 input logic [23:0] pi, input logic rdy, input logic err);
        return {o, oe, pi, rdy, err};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [31:0] d);
        int budget;
        budget = 20;
        pkt_if.pkt_data  = d;
        pkt_if.pkt_valid = 1'b1;
        while (pkt_if.pkt_ready !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (budget == 0) begin
            failures++;
            $display("FAIL send_ready_timeout: pkt_ready=%b, required 1 for packet %h", pkt_if.pkt_ready, d);
        end
        @(negedge clk);
        pkt_if.pkt_valid = 1'b0;
        pkt_if.pkt_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        periph_out = '1;
        periph_oe  = '1;
        dut_pin_in = '1;
        sb.push_back('{"reset_hold", mk(16'h0, 16'h0, 24'h0, 1'b0, 1'b0)});
        step(3);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin failures++; $display("FAIL %s: got out=%h oe=%h in=%h rdy=%b err=%b, required out=%h oe=%h in=%h rdy=%b err=%b", e.tag, obs.pin_out, obs.pin_oe, obs.pin_in, obs.ready, obs.err, e.v.pin_out, e.v.pin_oe, e.v.pin_in, e.v.ready, e.v.err); end
        rst = 1'b0;
        sb.push_back('{"reset_release", mk(16'h0, 16'h0, 24'h0, 1'b1, 1'b0)});
        sb.push_back('{"reset_idle_all_ones", mk(16'h0, 16'h0, 24'h0, 1'b1, 1'b0)});
        #1;
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin failures++; $display("FAIL %s: got out=%h oe=%h in=%h rdy=%b err=%b, required out=%h oe=%h in=%h rdy=%b err=%b", e.tag, obs.pin_out, obs.pin_oe, obs.pin_in, obs.ready, obs.err, e.v.pin_out, e.v.pin_oe, e.v.pin_in, e.v.ready, e.v.err); end
        step(4);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin failures++; $display("FAIL %s: got out=%h oe=%h in=%h rdy=%b err=%b, required out=%h oe=%h in=%h rdy=%b err=%b", e.tag, obs.pin_out, obs.pin_oe, obs.pin_in, obs.ready, obs.err, e.v.pin_out, e.v.pin_oe, e.v.pin_in, e.v.ready, e.v.err); end
        periph_out = 32'h0000_0200;
        periph_oe  = 8'h04;
        dut_pin_in = '0;
        step(3);
    endtask

    task automatic test_pinmap_commit();
        send(32'h5530_0000);
        sb.push_back('{"pinmap_uncommitted", mk(16'h0, 16'h0, 24'h0, 1'b1, 1'b0)});
        step(2);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin failures++; $display("FAIL %s: got out=%h oe=%h in=%h rdy=%b err=%b, required out=%h oe=%h in=%h rdy=%b err=%b", e.tag, obs.pin_out, obs.pin_oe, obs.pin_in, obs.ready, obs.err, e.v.pin_out, e.v.pin_oe, e.v.pin_in, e.v.ready, e.v.err); end
        send(COMMIT);
        sb.push_back('{"commit_copy_cycle", mk(16'h0, 16'h0, 24'h0, 1'b0, 1'b0)});
        sb.push_back('{"commit_edge1", mk(16'h0, 16'h0, 24'h0, 1'b1, 1'b0)});
        sb.push_back('{"commit_edge2", mk(16'h0020, 16'h0020, 24'h0, 1'b1, 1'b0)});
        for (int c = 0; c < 3; c++) begin
            if (c > 0) step(1);
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin failures++; $display("FAIL %s: got out=%h oe=%h in=%h rdy=%b err=%b, required out=%h oe=%h in=%h rdy=%b err=%b", e.tag, obs.pin_out, obs.pin_oe, obs.pin_in, obs.ready, obs.err, e.v.pin_out, e.v.pin_oe, e.v.pin_in, e.v.ready, e.v.err); end
        end
        periph_out = 32'h0;
        sb.push_back('{"out_lat_0", mk(16'h0020, 16'h0020, 24'h0, 1'b1, 1'b0)});
        sb.push_back('{"out_lat_1", mk(16'h0000, 16'h0020, 24'h0, 1'b1, 1'b0)});
        for (int c = 0; c < 2; c++) begin
            if (c > 0) step(1);
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin failures++; $display("FAIL %s: got out=%h oe=%h in=%h rdy=%b err=%b, required out=%h oe=%h in=%h rdy=%b err=%b", e.tag, obs.pin_out, obs.pin_oe, obs.pin_in, obs.ready, obs.err, e.v.pin_out, e.v.pin_oe, e.v.pin_in, e.v.ready, e.v.err); end
        end
        periph_out = 32'h0000_0200;
        step(1);
    endtask

    task automatic test_inmap();
        send(32'h9D30_0000);
        dut_pin_in[9] = 1'b1;
        sb.push_back('{"inmap_uncommitted", mk(16'h0020, 16'h0020, 24'h0, 1'b1, 1'b0)});
        step(4);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin failures++; $display("FAIL %s: got out=%h oe=%h in=%h rdy=%b err=%b, required out=%h oe=%h in=%h rdy=%b err=%b", e.tag, obs.pin_out, obs.pin_oe, obs.pin_in, obs.ready, obs.err, e.v.pin_out, e.v.pin_oe, e.v.pin_in, e.v.ready, e.v.err); end
        send(COMMIT);
        sb.push_back('{"inmap_copy_cycle", mk(16'h0020, 16'h0020, 24'h0, 1'b0, 1'b0)});
        sb.push_back('{"inmap_edge1", mk(16'h0020, 16'h0020, 24'h0, 1'b1, 1'b0)});
        sb.push_back('{"inmap_edge2", mk(16'h0020, 16'h0020, 24'h000800, 1'b1, 1'b0)});
        for (int c = 0; c < 3; c++) begin
            if (c > 0) step(1);
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin failures++; $display("FAIL %s: got out=%h oe=%h in=%h rdy=%b err=%b, required out=%h oe=%h in=%h rdy=%b err=%b", e.tag, obs.pin_out, obs.pin_oe, obs.pin_in, obs.ready, obs.err, e.v.pin_out, e.v.pin_oe, e.v.pin_in, e.v.ready, e.v.err); end
        end
        for (int t = 0; t < 2; t++) begin
            dut_pin_in[9] = (t == 1);
            sb.push_back('{"in_lat_1", mk(16'h0020, 16'h0020, (t == 1) ? 24'h0 : 24'h000800, 1'b1, 1'b0)});
            sb.push_back('{"in_lat_2", mk(16'h0020, 16'h0020, (t == 1) ? 24'h0 : 24'h000800, 1'b1, 1'b0)});
            sb.push_back('{"in_lat_3", mk(16'h0020, 16'h0020, (t == 1) ? 24'h000800 : 24'h0, 1'b1, 1'b0)});
            for (int c = 0; c < 3; c++) begin
                step(1);
                e = sb.pop_front(); checks++;
                if (obs !== e.v) begin failures++; $display("FAIL %s: got out=%h oe=%h in=%h rdy=%b err=%b, required out=%h oe=%h in=%h rdy=%b err=%b", e.tag, obs.pin_out, obs.pin_oe, obs.pin_in, obs.ready, obs.err, e.v.pin_out, e.v.pin_oe, e.v.pin_in, e.v.ready, e.v.err); end
            end
        end
    endtask

    task automatic test_invalid();
        dut_pin_in[0] = 1'b1;
        send(32'h8610_0000);
        sb.push_back('{"invalid_sets_err", mk(16'h0020, 16'h0020, 24'h000800, 1'b1, 1'b1)});
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin failures++; $display("FAIL %s: got out=%h oe=%h in=%h rdy=%b err=%b, required out=%h oe=%h in=%h rdy=%b err=%b", e.tag, obs.pin_out, obs.pin_oe, obs.pin_in, obs.ready, obs.err, e.v.pin_out, e.v.pin_oe, e.v.pin_in, e.v.ready, e.v.err); end
        send(COMMIT);
        sb.push_back('{"invalid_map_unchanged", mk(16'h0020, 16'h0020, 24'h000800, 1'b1, 1'b1)});
        step(3);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin failures++; $display("FAIL %s: got out=%h oe=%h in=%h rdy=%b err=%b, required out=%h oe=%h in=%h rdy=%b err=%b", e.tag, obs.pin_out, obs.pin_oe, obs.pin_in, obs.ready, obs.err, e.v.pin_out, e.v.pin_oe, e.v.pin_in, e.v.ready, e.v.err); end
        send(32'h0000_0000);
        sb.push_back('{"clear_err", mk(16'h0020, 16'h0020, 24'h000800, 1'b1, 1'b0)});
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin failures++; $display("FAIL %s: got out=%h oe=%h in=%h rdy=%b err=%b, required out=%h oe=%h in=%h rdy=%b err=%b", e.tag, obs.pin_out, obs.pin_oe, obs.pin_in, obs.ready, obs.err, e.v.pin_out, e.v.pin_oe, e.v.pin_in, e.v.ready, e.v.err); end
    endtask

    task automatic test_fanout_boundary();
        periph_out = 32'h8000_0200;
        periph_oe  = 8'h84;
        sb.push_back('{"fanout_premap", mk(16'h0020, 16'h0020, 24'h000800, 1'b1, 1'b0)});
        step(1);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin failures++; $display("FAIL %s: got out=%h oe=%h in=%h rdy=%b err=%b, required out=%h oe=%h in=%h rdy=%b err=%b", e.tag, obs.pin_out, obs.pin_oe, obs.pin_in, obs.ready, obs.err, e.v.pin_out, e.v.pin_oe, e.v.pin_in, e.v.ready, e.v.err); end
        send(32'h7130_0000);
        send(32'h7FF0_0000);
        send(COMMIT);
        sb.push_back('{"fanout_commit", mk(16'h9020, 16'h9020, 24'h000800, 1'b1, 1'b0)});
        sb.push_back('{"boundary_out_drop", mk(16'h1020, 16'h9020, 24'h000800, 1'b1, 1'b0)});
        step(2);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin failures++; $display("FAIL %s: got out=%h oe=%h in=%h rdy=%b err=%b, required out=%h oe=%h in=%h rdy=%b err=%b", e.tag, obs.pin_out, obs.pin_oe, obs.pin_in, obs.ready, obs.err, e.v.pin_out, e.v.pin_oe, e.v.pin_in, e.v.ready, e.v.err); end
        periph_out = 32'h0000_0200;
        step(1);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin failures++; $display("FAIL %s: got out=%h oe=%h in=%h rdy=%b err=%b, required out=%h oe=%h in=%h rdy=%b err=%b", e.tag, obs.pin_out, obs.pin_oe, obs.pin_in, obs.ready, obs.err, e.v.pin_out, e.v.pin_oe, e.v.pin_in, e.v.ready, e.v.err); end
    endtask

    task automatic test_shadow_rewrite();
        send(32'h5400_0000);
        sb.push_back('{"rewrite_uncommitted", mk(16'h1020, 16'h9020, 24'h000800, 1'b1, 1'b0)});
        sb.push_back('{"rewrite_commit", mk(16'h1000, 16'h9000, 24'h000800, 1'b1, 1'b0)});
        step(3);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin failures++; $display("FAIL %s: got out=%h oe=%h in=%h rdy=%b err=%b, required out=%h oe=%h in=%h rdy=%b err=%b", e.tag, obs.pin_out, obs.pin_oe, obs.pin_in, obs.ready, obs.err, e.v.pin_out, e.v.pin_oe, e.v.pin_in, e.v.ready, e.v.err); end
        send(COMMIT);
        step(2);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin failures++; $display("FAIL %s: got out=%h oe=%h in=%h rdy=%b err=%b, required out=%h oe=%h in=%h rdy=%b err=%b", e.tag, obs.pin_out, obs.pin_oe, obs.pin_in, obs.ready, obs.err, e.v.pin_out, e.v.pin_oe, e.v.pin_in, e.v.ready, e.v.err); end
    endtask

    task automatic test_reset_during_copy();
        send(COMMIT);
        rst = 1'b1;
        sb.push_back('{"rst_in_copy", mk(16'h0, 16'h0, 24'h0, 1'b0, 1'b0)});
        sb.push_back('{"rst_copy_release", mk(16'h0, 16'h0, 24'h0, 1'b1, 1'b0)});
        sb.push_back('{"rst_copy_map_empty", mk(16'h0, 16'h0, 24'h0, 1'b1, 1'b0)});
        step(1);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin failures++; $display("FAIL %s: got out=%h oe=%h in=%h rdy=%b err=%b, required out=%h oe=%h in=%h rdy=%b err=%b", e.tag, obs.pin_out, obs.pin_oe, obs.pin_in, obs.ready, obs.err, e.v.pin_out, e.v.pin_oe, e.v.pin_in, e.v.ready, e.v.err); end
        rst = 1'b0;
        #1;
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin failures++; $display("FAIL %s: got out=%h oe=%h in=%h rdy=%b err=%b, required out=%h oe=%h in=%h rdy=%b err=%b", e.tag, obs.pin_out, obs.pin_oe, obs.pin_in, obs.ready, obs.err, e.v.pin_out, e.v.pin_oe, e.v.pin_in, e.v.ready, e.v.err); end
        step(3);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin failures++; $display("FAIL %s: got out=%h oe=%h in=%h rdy=%b err=%b, required out=%h oe=%h in=%h rdy=%b err=%b", e.tag, obs.pin_out, obs.pin_oe, obs.pin_in, obs.ready, obs.err, e.v.pin_out, e.v.pin_oe, e.v.pin_in, e.v.ready, e.v.err); end
        send(COMMIT);
        sb.push_back('{"empty_commit_edge2", mk(16'h0, 16'h0, 24'h0, 1'b1, 1'b0)});
        sb.push_back('{"empty_commit_settled", mk(16'h0, 16'h0, 24'h0, 1'b1, 1'b0)});
        for (int c = 0; c < 2; c++) begin
            step(c == 0 ? 2 : 3);
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin failures++; $display("FAIL %s: got out=%h oe=%h in=%h rdy=%b err=%b, required out=%h oe=%h in=%h rdy=%b err=%b", e.tag, obs.pin_out, obs.pin_oe, obs.pin_in, obs.ready, obs.err, e.v.pin_out, e.v.pin_oe, e.v.pin_in, e.v.ready, e.v.err); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        rst              = 1'b1;
        pkt_if.pkt_data  = '0;
        pkt_if.pkt_valid = 1'b0;
        periph_out       = '0;
        periph_oe        = '0;
        dut_pin_in       = '0;
        @(negedge clk);
        test_reset();
        test_pinmap_commit();
        test_inmap();
        test_invalid();
        test_fanout_boundary();
        test_shadow_rewrite();
        test_reset_during_copy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
